// File: rtl/consumidor_contador.sv
// consumidor_contador: drains the D0/D1 FIFOs with round-robin arbitration, forwards popped words
// and keeps per-destination word counts readable through an idle-gated query port.
module consumidor_contador #(
  parameter int BW = 6,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          D0_empty,
  input  logic          D1_empty,
  input  logic [BW-1:0] D0_data_out,
  input  logic [BW-1:0] D1_data_out,
  input  logic          idle,
  input  logic          req,
  input  logic [1:0]    idx,
  output logic          D0_rd,
  output logic          D1_rd,
  output logic [BW-1:0] word_out,
  output logic          word_dest,
  output logic          word_valid,
  output logic [CW-1:0] data_cnt,
  output logic          valid
);
  typedef enum logic {S_RUN, S_QUERY} state_t;
  state_t state_q, state_d;
  logic last_q, word_dest_q, word_valid_q, valid_q;
  logic [BW-1:0] word_out_q;
  logic [CW-1:0] cnt0_q, cnt1_q, data_cnt_q, sum, sel;
  logic run;
  assign run   = reset_L && state_q == S_RUN;
  assign D0_rd = run && !D0_empty && (D1_empty || last_q);
  assign D1_rd = run && !D1_empty && (D0_empty || !last_q);
  assign sum   = cnt0_q + cnt1_q;
  always_comb begin
    state_d = state_q == S_RUN ? ((idle && req) ? S_QUERY : S_RUN) : (req ? S_QUERY : S_RUN);
    sel = idx == 2'd0 ? cnt0_q : idx == 2'd1 ? cnt1_q : idx == 2'd2 ? sum : '0;
  end
  // Popped word is sampled on the pop edge, so a pop in the last S_RUN cycle lands before the query.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= S_RUN;
      last_q       <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      word_out_q   <= '0;
      word_dest_q  <= 1'b0;
      word_valid_q <= 1'b0;
      data_cnt_q   <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_valid_q <= D0_rd || D1_rd;
      valid_q      <= state_q == S_QUERY;
      data_cnt_q   <= state_q == S_QUERY ? sel : '0;
      if (D0_rd || D1_rd) begin
        word_out_q  <= D1_rd ? D1_data_out : D0_data_out;
        word_dest_q <= D1_rd;
        last_q      <= D1_rd;
      end
      if (D0_rd) cnt0_q <= cnt0_q + 1'b1;
      if (D1_rd) cnt1_q <= cnt1_q + 1'b1;
    end
  end
  assign word_out   = word_out_q;
  assign word_dest  = word_dest_q;
  assign word_valid = word_valid_q;
  assign data_cnt   = data_cnt_q;
  assign valid      = valid_q;
endmodule
